// File: rtl/mm_pkg.sv
// Shared types and constants for the multimeter's UART receiver and command parser.
package mm_pkg;
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} uart_rx_state_t;
    typedef enum logic [1:0] {P_IDLE, P_ARG, P_EOL} cmd_state_t;
    typedef logic [1:0] result_sel_t;

    localparam logic [7:0] CMD_SEL  = 8'h53;
    localparam logic [7:0] CMD_EN   = 8'h45;
    localparam logic [7:0] CMD_DIS  = 8'h44;
    localparam logic [7:0] ASCII_CR = 8'h0D;
    localparam logic [7:0] ASCII_LF = 8'h0A;

    // Valid 'S' arguments are the ASCII digits '0'..'3'.
    function automatic logic is_sel_arg(input logic [7:0] b);
        return (b >= 8'h30) && (b <= 8'h33);
    endfunction
endpackage

// File: rtl/uart_rx.sv
// 8N1 receiver: rxd synchroniser, mid-bit baud counter and RX FSM.
// Emits each correctly framed byte with a 1-cycle valid pulse, or a frame error pulse.
module uart_rx
    import mm_pkg::*;
#(
    parameter int CLK_FREQ = 100_000_000,
    parameter int BAUD     = 115_200
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clr_i,
    input  logic       rxd_i,
    output logic [7:0] byte_o,
    output logic       byte_valid_o,
    output logic       frame_err_o
);
    localparam int DIV   = (CLK_FREQ + BAUD / 2) / BAUD;
    localparam int CNT_W = $clog2(DIV);
    localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(DIV / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(DIV - 1);

    uart_rx_state_t   state, state_next;
    logic [1:0]       sync;
    logic             rxd_s;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       bit_cnt;
    logic [7:0]       shift;
    logic             cnt_load, shift_en, bit_clr, valid_next, ferr_next;
    logic [CNT_W-1:0] cnt_val;

    assign rxd_s = sync[1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= RX_IDLE;
        end else if (clr_i) begin
            state <= RX_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        cnt_load   = 1'b0;
        cnt_val    = '0;
        shift_en   = 1'b0;
        bit_clr    = 1'b0;
        valid_next = 1'b0;
        ferr_next  = 1'b0;
        unique case (state)
            RX_IDLE: begin
                if (!rxd_s) begin
                    cnt_load   = 1'b1;
                    cnt_val    = HALF_M1;
                    state_next = RX_START;
                end
            end
            RX_START: begin
                // A start bit that is high again at mid-bit was only a glitch.
                if (cnt == '0) begin
                    if (!rxd_s) begin
                        cnt_load   = 1'b1;
                        cnt_val    = FULL_M1;
                        bit_clr    = 1'b1;
                        state_next = RX_DATA;
                    end else begin
                        state_next = RX_IDLE;
                    end
                end
            end
            RX_DATA: begin
                if (cnt == '0) begin
                    shift_en = 1'b1;
                    cnt_load = 1'b1;
                    cnt_val  = FULL_M1;
                    if (bit_cnt == 3'd7) state_next = RX_STOP;
                end
            end
            RX_STOP: begin
                if (cnt == '0) begin
                    state_next = RX_IDLE;
                    valid_next = rxd_s;
                    ferr_next  = !rxd_s;
                end
            end
            default: state_next = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync         <= 2'b11;
            cnt          <= '0;
            bit_cnt      <= '0;
            shift        <= '0;
            byte_o       <= '0;
            byte_valid_o <= 1'b0;
            frame_err_o  <= 1'b0;
        end else if (clr_i) begin
            sync         <= 2'b11;
            cnt          <= '0;
            bit_cnt      <= '0;
            shift        <= '0;
            byte_o       <= '0;
            byte_valid_o <= 1'b0;
            frame_err_o  <= 1'b0;
        end else begin
            sync <= {sync[0], rxd_i};
            if (cnt_load)        cnt <= cnt_val;
            else if (cnt != '0)  cnt <= cnt - 1'b1;
            if (bit_clr)         bit_cnt <= '0;
            else if (shift_en)   bit_cnt <= bit_cnt + 1'b1;
            if (shift_en)        shift <= {rxd_s, shift[7:1]};
            if (valid_next)      byte_o <= shift;
            byte_valid_o <= valid_next;
            frame_err_o  <= ferr_next;
        end
    end
endmodule

// File: rtl/uart_rx_cmd.sv
// UART command front-end: receives bytes and parses 'S<n>', 'E', 'D' + CR commands
// into override registers for result selection and the UART-transmit enable.
module uart_rx_cmd
    import mm_pkg::*;
#(
    parameter int CLK_FREQ = 100_000_000,
    parameter int BAUD     = 115_200
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rxd_i,
    input  logic       clr_i,
    output logic [7:0] byte_o,
    output logic       byte_valid_o,
    output logic       frame_err_o,
    output logic [1:0] sel_o,
    output logic       sel_valid_o,
    output logic       uart_en_o,
    output logic       uart_en_vld_o,
    output logic       cmd_update_o,
    output logic       cmd_err_o
);
    cmd_state_t  p_state, p_next;
    logic [7:0]  op, op_next;
    result_sel_t arg, arg_next;
    logic        upd_next, err_next;

    uart_rx #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD)) u_rx (
        .clk          (clk),
        .rst_n        (rst_n),
        .clr_i        (clr_i),
        .rxd_i        (rxd_i),
        .byte_o       (byte_o),
        .byte_valid_o (byte_valid_o),
        .frame_err_o  (frame_err_o)
    );

    always_comb begin
        p_next   = p_state;
        op_next  = op;
        arg_next = arg;
        upd_next = 1'b0;
        err_next = 1'b0;
        // A framing error silently discards any partially received command.
        if (frame_err_o) begin
            p_next = P_IDLE;
        end else if (byte_valid_o) begin
            unique case (p_state)
                P_IDLE: begin
                    if (byte_o == CMD_SEL) begin
                        op_next = byte_o;
                        p_next  = P_ARG;
                    end else if (byte_o == CMD_EN || byte_o == CMD_DIS) begin
                        op_next = byte_o;
                        p_next  = P_EOL;
                    end else if (byte_o != ASCII_CR && byte_o != ASCII_LF) begin
                        err_next = 1'b1;
                    end
                end
                P_ARG: begin
                    if (is_sel_arg(byte_o)) begin
                        arg_next = byte_o[1:0];
                        p_next   = P_EOL;
                    end else begin
                        err_next = 1'b1;
                        p_next   = P_IDLE;
                    end
                end
                P_EOL: begin
                    p_next   = P_IDLE;
                    upd_next = (byte_o == ASCII_CR);
                    err_next = (byte_o != ASCII_CR);
                end
                default: p_next = P_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p_state       <= P_IDLE;
            op            <= '0;
            arg           <= '0;
            sel_o         <= '0;
            sel_valid_o   <= 1'b0;
            uart_en_o     <= 1'b0;
            uart_en_vld_o <= 1'b0;
            cmd_update_o  <= 1'b0;
            cmd_err_o     <= 1'b0;
        end else if (clr_i) begin
            p_state       <= P_IDLE;
            op            <= '0;
            arg           <= '0;
            sel_o         <= '0;
            sel_valid_o   <= 1'b0;
            uart_en_o     <= 1'b0;
            uart_en_vld_o <= 1'b0;
            cmd_update_o  <= 1'b0;
            cmd_err_o     <= 1'b0;
        end else begin
            p_state      <= p_next;
            op           <= op_next;
            arg          <= arg_next;
            cmd_update_o <= upd_next;
            cmd_err_o    <= err_next;
            if (upd_next) begin
                if (op == CMD_SEL) begin
                    sel_o       <= arg;
                    sel_valid_o <= 1'b1;
                end else begin
                    uart_en_o     <= (op == CMD_EN);
                    uart_en_vld_o <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_uart_rx_cmd.sv
// Bench for uart_rx_cmd: directed command scenarios plus a random byte stream,
// checked against a command-buffer model of the protocol.
module tb_uart_rx_cmd;
    localparam int DIV = 10;
    localparam logic [7:0] CH_S = 8'h53, CH_E = 8'h45, CH_D = 8'h44;
    localparam logic [7:0] CH_CR = 8'h0D, CH_LF = 8'h0A;

    logic       clk = 1'b0, rst_n = 1'b0, rxd = 1'b1, clr = 1'b0;
    logic [7:0] byte_o;
    logic       byte_valid, frame_err, sel_valid, uart_en, uart_en_vld, cmd_update, cmd_err;
    logic [1:0] sel;

    uart_rx_cmd #(.CLK_FREQ(1_000_000), .BAUD(100_000)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .rxd_i         (rxd),
        .clr_i         (clr),
        .byte_o        (byte_o),
        .byte_valid_o  (byte_valid),
        .frame_err_o   (frame_err),
        .sel_o         (sel),
        .sel_valid_o   (sel_valid),
        .uart_en_o     (uart_en),
        .uart_en_vld_o (uart_en_vld),
        .cmd_update_o  (cmd_update),
        .cmd_err_o     (cmd_err)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- scoreboard / model state ----------------
    int checks = 0, failures = 0;
    logic [7:0] exp_q[$];
    logic [7:0] pend[$];
    logic [1:0] m_sel;
    logic       m_sel_vld, m_en, m_en_vld;
    int exp_upd = 0, exp_err = 0, exp_ferr = 0;
    int got_upd = 0, got_err = 0, got_ferr = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic void model_clear();
        pend.delete();
        m_sel = '0; m_sel_vld = 1'b0; m_en = 1'b0; m_en_vld = 1'b0;
    endfunction

    // Command buffer model: collect opcode (+arg), execute when CR completes it.
    function automatic void model_byte(input logic [7:0] b);
        if (pend.size() == 0) begin
            if (b == CH_S || b == CH_E || b == CH_D) pend.push_back(b);
            else if (b != CH_CR && b != CH_LF) exp_err++;
        end else if (pend[0] == CH_S && pend.size() == 1) begin
            if (b >= 8'h30 && b <= 8'h33) pend.push_back(b);
            else begin exp_err++; pend.delete(); end
        end else begin
            if (b == CH_CR) begin
                exp_upd++;
                if (pend[0] == CH_S) begin m_sel = pend[1][1:0]; m_sel_vld = 1'b1; end
                else begin m_en = (pend[0] == CH_E); m_en_vld = 1'b1; end
            end else begin
                exp_err++;
            end
            pend.delete();
        end
    endfunction

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (rst_n) begin
            if (byte_valid) begin
                check_eq("byte_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) check_eq("byte", byte_o, exp_q.pop_front());
            end
            if (byte_valid || frame_err) check_eq("rx_excl", byte_valid & frame_err, 0);
            if (cmd_update || cmd_err)   check_eq("cmd_excl", cmd_update & cmd_err, 0);
            if (cmd_update) got_upd++;
            if (cmd_err)    got_err++;
            if (frame_err)  got_ferr++;
        end
    end

    // ---------------- driver tasks (called at posedge+1) ----------------
    task automatic bit_out(input logic v);
        rxd = v;
        repeat (DIV) @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        rxd = 1'b1;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_ok, input int gap);
        if (stop_ok) begin
            exp_q.push_back(b);
            model_byte(b);
        end else begin
            exp_ferr++;
            pend.delete();
        end
        bit_out(1'b0);
        for (int i = 0; i < 8; i++) bit_out(b[i]);
        bit_out(stop_ok);
        idle(gap);
    endtask

    task automatic check_overrides(input string tag);
        check_eq({tag, "_sel"}, sel, m_sel);
        check_eq({tag, "_sel_vld"}, sel_valid, m_sel_vld);
        check_eq({tag, "_en"}, uart_en, m_en);
        check_eq({tag, "_en_vld"}, uart_en_vld, m_en_vld);
    endtask

    task automatic check_all(input string tag);
        idle(8);
        check_overrides(tag);
        check_eq({tag, "_upd_cnt"}, got_upd, exp_upd);
        check_eq({tag, "_err_cnt"}, got_err, exp_err);
        check_eq({tag, "_ferr_cnt"}, got_ferr, exp_ferr);
        check_eq({tag, "_bytes_left"}, exp_q.size(), 0);
    endtask

    // ---------------- stimulus ----------------
    logic [7:0] pool [12];
    logic [7:0] b;

    initial begin
        pool = '{CH_S, CH_E, CH_D, CH_CR, CH_LF, 8'h30, 8'h31, 8'h32, 8'h33, 8'h37, 8'h73, 8'h00};
        model_clear();
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        idle(2);
        check_eq("rst_byte", byte_o, 0);
        check_eq("rst_pulses", {byte_valid, frame_err, cmd_update, cmd_err}, 0);
        check_overrides("rst");

        // 1: S2 CR
        send_frame(CH_S, 1'b1, 3); send_frame(8'h32, 1'b1, 3); send_frame(CH_CR, 1'b1, 3);
        check_all("s2");
        check_eq("s2_sel_val", sel, 2'b10);

        // 2: E CR then D CR, back-to-back frames
        send_frame(CH_E, 1'b1, 0); send_frame(CH_CR, 1'b1, 0);
        idle(4);
        check_eq("en_on", uart_en, 1);
        send_frame(CH_D, 1'b1, 0); send_frame(CH_CR, 1'b1, 0);
        check_all("ed");

        // 3: bad argument, then stray CR ignored
        send_frame(CH_S, 1'b1, 3); send_frame(8'h37, 1'b1, 3); send_frame(CH_CR, 1'b1, 3);
        check_all("badarg");

        // 4: framing error on 'S', then '1' CR is a fresh (bad) command
        send_frame(CH_S, 1'b0, 3);
        send_frame(8'h31, 1'b1, 3); send_frame(CH_CR, 1'b1, 3);
        check_all("ferr");

        // 5: 3-clk glitch
        rxd = 1'b0;
        repeat (3) @(posedge clk);
        #1 rxd = 1'b1;
        idle(30);
        check_all("glitch");

        // 6: S1 CR, then clr during bit 4 of 0xF0
        send_frame(CH_S, 1'b1, 3); send_frame(8'h31, 1'b1, 3); send_frame(CH_CR, 1'b1, 3);
        check_all("s1");
        bit_out(1'b0);
        for (int i = 0; i < 4; i++) bit_out(1'b0);
        rxd = 1'b1;
        repeat (3) @(posedge clk);
        #1 clr = 1'b1;
        @(posedge clk);
        #1 clr = 1'b0;
        model_clear();
        check_eq("clr_byte", byte_o, 0);
        check_overrides("clr");
        repeat (DIV - 4) @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) bit_out(1'b1);
        check_all("clr_abort");
        send_frame(CH_S, 1'b1, 3); send_frame(8'h33, 1'b1, 3); send_frame(CH_CR, 1'b1, 3);
        check_all("s3");

        // Random byte stream with occasional framing errors
        for (int n = 0; n < 60; n++) begin
            b = pool[$urandom_range(0, 11)];
            if (b == 8'h00) b = 8'($urandom_range(0, 255));
            send_frame(b, $urandom_range(0, 9) != 0, $urandom_range(2, 6));
            check_overrides("rnd");
        end
        check_all("rnd_end");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
